vmem_arb: RTL and testbench

Single-port SRAM arbiter and sequencer between the scanout fetch path and the command decoder's pixel-write path. Detects a completed 3-byte pixel from the decoder and latches it through the decoder's hold handshake. Serialises the pixel into three SRAM byte writes. Interleaves those writes with fixed-length read bursts requested by scanout, alternating grants when both sides are pending.

---
 rtl/vmem_arb.sv | 202 ++++++++++++++++++++
 tb/tb_vmem_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_arb.sv
// vmem_arb: single-port SRAM arbiter between scanout fetch bursts and the
// command decoder's 3-byte pixel writes.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_fetch_req/addr        scanout burst request (level) and start address
//   o_fetch_ack             pulse: burst granted, i_fetch_addr latched
//   o_fetch_data/valid/done read byte stream, done on the last byte
//   i_wr_rdy                decoder DataRdy (asynchronous to i_clk)
//   i_wr_addr/data          decoder pixel base address and selected byte
//   o_wr_index              decoder byte select (0..2)
//   o_wr_hold               decoder HoldUpdate; low for one cycle to latch a pixel
//   o_wr_overrun            pulse: new pixel arrived while one was pending
//   o_mem_*/i_mem_din       SRAM bus (active-low WE/OE, tristate enable)
module vmem_arb #(
   parameter int unsigned MEM_TOP   = 230400,
   parameter int unsigned BURST_LEN = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_fetch_req,
   input  logic [18:0] i_fetch_addr,
   output logic        o_fetch_ack,
   output logic [7:0]  o_fetch_data,
   output logic        o_fetch_valid,
   output logic        o_fetch_done,
   input  logic        i_wr_rdy,
   input  logic [18:0] i_wr_addr,
   input  logic [7:0]  i_wr_data,
   output logic [1:0]  o_wr_index,
   output logic        o_wr_hold,
   output logic        o_wr_overrun,
   output logic [18:0] o_mem_addr,
   output logic [7:0]  o_mem_dout,
   input  logic [7:0]  i_mem_din,
   output logic        o_mem_we_n,
   output logic        o_mem_oe_n,
   output logic        o_mem_dout_en
);

   localparam int unsigned AW = 19;
   localparam int unsigned CW = 6;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_W_LATCH  = 3'd1,
      S_W_SETTLE = 3'd2,
      S_W_SETUP  = 3'd3,
      S_W_STROBE = 3'd4,
      S_R_ADDR   = 3'd5,
      S_R_SAMPLE = 3'd6
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [1:0]      r_sync;
   logic            r_rdy_d;
   logic            r_pend;
   logic            r_last_fetch;
   logic [AW-1:0]   r_ptr;
   logic [CW-1:0]   r_cnt;

   logic            w_rise;
   logic [AW-1:0]   w_ptr_inc;
   logic [AW-1:0]   w_ptr_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_fetch_grant;
   logic            w_wr_grant;
   logic            w_burst_last;
   logic            w_nxt_wr_bus;
   logic            w_nxt_rd_bus;

   // Rising edge of the synchronised decoder ready
   assign w_rise       = r_sync[1] & ~r_rdy_d;
   // Address increment with wrap at the top of the frame buffer
   assign w_ptr_inc    = (r_ptr == AW'(MEM_TOP - 1)) ? '0 : r_ptr + AW'(1);
   assign w_burst_last = (r_cnt == CW'(BURST_LEN - 1));
   assign w_nxt_wr_bus = (w_state_nxt == S_W_SETUP) || (w_state_nxt == S_W_STROBE);
   assign w_nxt_rd_bus = (w_state_nxt == S_R_ADDR)  || (w_state_nxt == S_R_SAMPLE);

   // Synchroniser, pending-pixel flag and fairness bit
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync       <= '0;
         r_rdy_d      <= 1'b0;
         r_pend       <= 1'b0;
         r_last_fetch <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_wr_rdy};
         r_rdy_d <= r_sync[1];
         if (w_rise)
            r_pend <= 1'b1;
         else if (r_state == S_W_LATCH)
            r_pend <= 1'b0;
         if (w_fetch_grant)
            r_last_fetch <= 1'b1;
         else if (w_wr_grant)
            r_last_fetch <= 1'b0;
      end
   end

   // State, pointer and byte counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state and grant logic
   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_cnt_nxt     = r_cnt;
      w_fetch_grant = 1'b0;
      w_wr_grant    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            // Pixel wins when alone, or on a tie if the last grant was a fetch
            if (r_pend && (r_last_fetch || !i_fetch_req)) begin
               w_wr_grant  = 1'b1;
               w_state_nxt = S_W_LATCH;
            end else if (i_fetch_req) begin
               w_fetch_grant = 1'b1;
               w_state_nxt   = S_R_ADDR;
               w_ptr_nxt     = i_fetch_addr;
               w_cnt_nxt     = '0;
            end
         end
         S_W_LATCH: w_state_nxt = S_W_SETTLE;
         S_W_SETTLE: begin
            w_state_nxt = S_W_SETUP;
            w_ptr_nxt   = i_wr_addr;
            w_cnt_nxt   = '0;
         end
         S_W_SETUP: w_state_nxt = S_W_STROBE;
         S_W_STROBE: begin
            if (r_cnt == CW'(2)) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_W_SETUP;
               w_ptr_nxt   = w_ptr_inc;
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
         S_R_ADDR: w_state_nxt = S_R_SAMPLE;
         S_R_SAMPLE: begin
            if (w_burst_last) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_R_ADDR;
               w_ptr_nxt   = w_ptr_inc;
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Registered outputs, decoded from the state being entered so they line up with it
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_fetch_ack   <= 1'b0;
         o_fetch_data  <= '0;
         o_fetch_valid <= 1'b0;
         o_fetch_done  <= 1'b0;
         o_wr_index    <= '0;
         o_wr_hold     <= 1'b1;
         o_wr_overrun  <= 1'b0;
         o_mem_addr    <= '0;
         o_mem_dout    <= '0;
         o_mem_we_n    <= 1'b1;
         o_mem_oe_n    <= 1'b1;
         o_mem_dout_en <= 1'b0;
      end else begin
         o_fetch_ack   <= w_fetch_grant;
         o_fetch_valid <= (r_state == S_R_SAMPLE);
         o_fetch_done  <= (r_state == S_R_SAMPLE) && w_burst_last;
         if (r_state == S_R_SAMPLE)
            o_fetch_data <= i_mem_din;
         o_wr_hold     <= (w_state_nxt != S_W_LATCH);
         // A pixel being consumed in W_LATCH is not an overrun of the next one
         o_wr_overrun  <= w_rise && r_pend && (r_state != S_W_LATCH);
         o_mem_we_n    <= (w_state_nxt != S_W_STROBE);
         o_mem_oe_n    <= !w_nxt_rd_bus;
         o_mem_dout_en <= w_nxt_wr_bus;
         if (w_nxt_wr_bus || w_nxt_rd_bus)
            o_mem_addr <= w_ptr_nxt;
         if (w_nxt_wr_bus) begin
            o_wr_index <= w_cnt_nxt[1:0];
            // Resampled entering STROBE so the byte follows the index set in SETUP
            o_mem_dout <= i_wr_data;
         end
      end
   end

endmodule

// File: tb/tb_vmem_arb.sv
// Self-checking bench for vmem_arb: decoder and SRAM models, write/read
// scoreboards, table of single transactions plus multi-cycle corner cases.
module tb_vmem_arb;

   localparam int unsigned MEM_TOP = 230400;
   localparam int unsigned BL      = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req;
   logic [18:0] fetch_addr;
   logic        fetch_ack;
   logic [7:0]  fetch_data;
   logic        fetch_valid;
   logic        fetch_done;
   logic        wr_rdy;
   logic [18:0] wr_addr;
   logic [7:0]  wr_data;
   logic [1:0]  wr_index;
   logic        wr_hold;
   logic        wr_overrun;
   logic [18:0] mem_addr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        mem_we_n;
   logic        mem_oe_n;
   logic        mem_dout_en;

   vmem_arb #(.MEM_TOP(MEM_TOP), .BURST_LEN(BL)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
      .o_fetch_ack(fetch_ack), .o_fetch_data(fetch_data),
      .o_fetch_valid(fetch_valid), .o_fetch_done(fetch_done),
      .i_wr_rdy(wr_rdy), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .o_wr_index(wr_index), .o_wr_hold(wr_hold), .o_wr_overrun(wr_overrun),
      .o_mem_addr(mem_addr), .o_mem_dout(mem_dout), .i_mem_din(mem_din),
      .o_mem_we_n(mem_we_n), .o_mem_oe_n(mem_oe_n), .o_mem_dout_en(mem_dout_en)
   );

   always #5 clk = ~clk;

   // SRAM model returns the low address byte while output-enabled
   assign mem_din = mem_oe_n ? 8'h00 : mem_addr[7:0];

   // Decoder model: pixel latched on the falling edge of HoldUpdate
   logic [31:0] cur_pix, held_pix;
   logic [18:0] cur_addr, held_addr;
   always @(negedge wr_hold) begin
      held_pix  = cur_pix;
      held_addr = cur_addr;
   end
   assign wr_addr = held_addr;
   assign wr_data = held_pix[8*wr_index +: 8];

   typedef struct packed { logic [18:0] addr; logic [7:0] data; logic [1:0] idx; } wexp_t;
   typedef struct packed { logic [7:0] data; logic done; logic first; } rexp_t;
   typedef struct { logic is_fetch; logic [18:0] addr; logic [23:0] pix; logic [18:0] exp_last; } vec_t;

   wexp_t wq[$];
   rexp_t rq[$];
   byte   glog[$];

   int n_tests = 0, n_fail = 0;
   int cyc = 0, ack_cyc = 0, last_valid_cyc = 0;
   int n_strobes = 0, hold_cnt = 0, ovr_cnt = 0;
   logic [18:0] last_wr_addr = '0, last_rd_addr = '0;
   logic prev_hold = 1'b1;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic bad(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   function automatic logic [18:0] nxt(input logic [18:0] a);
      return (a == 19'(MEM_TOP - 1)) ? 19'd0 : a + 19'd1;
   endfunction

   // Output monitor and scoreboard consumer
   always @(negedge clk) begin
      wexp_t we;
      rexp_t re;
      if (rst_n) begin
         if (!mem_we_n) begin
            chk("no_bus_overlap", {31'd0, mem_oe_n}, 32'd1);
            chk("dout_en_in_strobe", {31'd0, mem_dout_en}, 32'd1);
            n_strobes++;
            last_wr_addr = mem_addr;
            if (wq.size() == 0) bad("unexpected write");
            else begin
               we = wq.pop_front();
               chk("wr_addr", 32'(mem_addr), 32'(we.addr));
               chk("wr_data", 32'(mem_dout), 32'(we.data));
               chk("wr_index", 32'(wr_index), 32'(we.idx));
            end
         end
         if (!mem_oe_n) last_rd_addr = mem_addr;
         if (fetch_ack) begin
            ack_cyc = cyc;
            glog.push_back(8'h46);
         end
         if (!wr_hold) begin
            chk("hold_one_cycle", {31'd0, prev_hold}, 32'd1);
            hold_cnt++;
            glog.push_back(8'h57);
         end
         if (wr_overrun) ovr_cnt++;
         if (fetch_done && !fetch_valid) bad("done without valid");
         if (fetch_valid) begin
            if (rq.size() == 0) bad("unexpected fetch_valid");
            else begin
               re = rq.pop_front();
               chk("rd_data", 32'(fetch_data), 32'(re.data));
               chk("rd_done", {31'd0, fetch_done}, {31'd0, re.done});
               if (re.first) chk("ack_to_valid", 32'(cyc - ack_cyc), 32'd2);
               else          chk("valid_spacing", 32'(cyc - last_valid_cyc), 32'd2);
            end
            last_valid_cyc = cyc;
         end
      end
      prev_hold = wr_hold;
   end

   task automatic push_pixel(input logic [18:0] a, input logic [23:0] p);
      logic [18:0] x;
      x = a;
      for (int k = 0; k < 3; k++) begin
         wq.push_back({x, p[8*k +: 8], 2'(k)});
         x = nxt(x);
      end
   endtask

   task automatic push_burst(input logic [18:0] a);
      logic [18:0] x;
      x = a;
      for (int k = 0; k < int'(BL); k++) begin
         rq.push_back({x[7:0], k == int'(BL) - 1, k == 0});
         x = nxt(x);
      end
   endtask

   task automatic rdy_pulse(input int hi, input int lo);
      wr_rdy = 1'b1;
      repeat (hi) @(negedge clk);
      wr_rdy = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic wait_ack(input string nm, input int budget);
      bit got;
      got = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (fetch_ack) begin got = 1; break; end
      end
      if (!got) bad(nm);
   endtask

   task automatic wait_drain(input string nm, input int budget);
      bit got;
      got = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (wq.size() == 0 && rq.size() == 0) begin got = 1; break; end
      end
      if (!got) bad(nm);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_hold"},    {31'd0, wr_hold},     32'd1);
      chk({tag, "_we_n"},    {31'd0, mem_we_n},    32'd1);
      chk({tag, "_oe_n"},    {31'd0, mem_oe_n},    32'd1);
      chk({tag, "_dout_en"}, {31'd0, mem_dout_en}, 32'd0);
      chk({tag, "_misc"}, {fetch_ack, fetch_valid, fetch_done, wr_overrun, wr_index}, 32'd0);
      chk({tag, "_addr"},    32'(mem_addr),   32'd0);
      chk({tag, "_dout"},    32'(mem_dout),   32'd0);
      chk({tag, "_fdata"},   32'(fetch_data), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[6];
      int s0, h0, o0;
      vecs[0] = '{1'b0, 19'h00300, 24'hCCBBAA, 19'h00302};
      vecs[1] = '{1'b1, 19'h00010, 24'h0,      19'h00017};
      vecs[2] = '{1'b0, 19'd230398, 24'h332211, 19'd0};
      vecs[3] = '{1'b1, 19'd230396, 24'h0,     19'd3};
      vecs[4] = '{1'b0, 19'd230399, 24'h665544, 19'd1};
      vecs[5] = '{1'b1, 19'h12345, 24'h0,      19'h1234C};

      rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; wr_rdy = 1'b0;
      cur_pix = '0; cur_addr = '0; held_pix = '0; held_addr = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single transactions
      foreach (vecs[i]) begin
         s0 = n_strobes; h0 = hold_cnt;
         if (vecs[i].is_fetch) begin
            push_burst(vecs[i].addr);
            fetch_addr = vecs[i].addr;
            fetch_req  = 1'b1;
            wait_ack("fetch ack timeout", 20);
            fetch_req  = 1'b0;
            fetch_addr = 19'h7FFFF;
            wait_drain("fetch drain timeout", 60);
            chk("fetch_last_addr", 32'(last_rd_addr), 32'(vecs[i].exp_last));
            chk("fetch_no_write", 32'(n_strobes - s0), 32'd0);
         end else begin
            push_pixel(vecs[i].addr, vecs[i].pix);
            cur_addr = vecs[i].addr;
            cur_pix  = {8'h00, vecs[i].pix};
            rdy_pulse(4, 2);
            wait_drain("pixel drain timeout", 60);
            chk("pixel_last_addr", 32'(last_wr_addr), 32'(vecs[i].exp_last));
            chk("pixel_strobes", 32'(n_strobes - s0), 32'd3);
            chk("pixel_hold_pulses", 32'(hold_cnt - h0), 32'd1);
         end
      end

      // Contention: fetch held and pixel arriving together
      glog.delete();
      push_burst(19'h00400);
      push_pixel(19'h00500, 24'h030201);
      push_burst(19'h00800);
      cur_addr = 19'h00500; cur_pix = 32'h00030201;
      fetch_addr = 19'h00400; fetch_req = 1'b1; wr_rdy = 1'b1;
      wait_ack("contention ack1 timeout", 20);
      fetch_addr = 19'h00800;
      wait_ack("contention ack2 timeout", 60);
      fetch_req = 1'b0; wr_rdy = 1'b0; fetch_addr = 19'h7FFFF;
      wait_drain("contention drain timeout", 80);
      chk("grant_count", 32'(glog.size()), 32'd3);
      if (glog.size() == 3) begin
         chk("grant0", 32'(glog[0]), 32'h46);
         chk("grant1", 32'(glog[1]), 32'h57);
         chk("grant2", 32'(glog[2]), 32'h46);
      end

      // Overrun: two pixels during one burst, only the newest written
      s0 = n_strobes; h0 = hold_cnt; o0 = ovr_cnt;
      push_burst(19'h02000);
      push_pixel(19'h03002, 24'hF3F2F1);
      fetch_addr = 19'h02000; fetch_req = 1'b1;
      wait_ack("overrun ack timeout", 20);
      fetch_req = 1'b0;
      cur_addr = 19'h03000; cur_pix = 32'h00E3E2E1;
      rdy_pulse(2, 2);
      cur_addr = 19'h03002; cur_pix = 32'h00F3F2F1;
      rdy_pulse(2, 2);
      wait_drain("overrun drain timeout", 80);
      chk("overrun_pulses", 32'(ovr_cnt - o0), 32'd1);
      chk("overrun_strobes", 32'(n_strobes - s0), 32'd3);
      chk("overrun_hold_pulses", 32'(hold_cnt - h0), 32'd1);

      // Reset during the strobe of byte 1
      push_pixel(19'h01000, 24'h332211);
      cur_addr = 19'h01000; cur_pix = 32'h00332211;
      wr_rdy = 1'b1;
      begin
         bit got;
         got = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 3) wr_rdy = 1'b0;
            if (!mem_we_n && wr_index == 2'd1) begin got = 1; break; end
         end
         if (!got) bad("byte1 strobe not seen");
      end
      wr_rdy = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      wq.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      s0 = n_strobes; h0 = hold_cnt;
      repeat (30) @(negedge clk);
      chk("post_reset_no_write", 32'(n_strobes - s0), 32'd0);
      chk("post_reset_no_hold", 32'(hold_cnt - h0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
